// File: rtl/rowsum_reader_d.sv
// rtl/rowsum_reader_d.sv - D-matrix row-sum reader with valid/ready row output
//
// Purpose:
//   Once the D-matrix BRAM reports it is fully written, sweep the M x R matrix
//   row by row through BRAM port B, sum each row, and hand one sum per row to
//   the next arithmetic stage over a valid/ready handshake. A running grand
//   total of all transferred rows is kept alongside.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous, active-high; clears all state
//   wrD_done   in   D BRAM fully written; only looked at while idle
//   addrbD     out  registered BRAM port-B read address
//   doutbD     in   BRAM read data, valid one cycle after addrbD
//   row_sum    out  unsigned sum of the row being presented
//   row_idx    out  row number of row_sum
//   row_valid  out  row_sum/row_idx valid
//   row_ready  in   consumer accepts; transfer when row_valid & row_ready
//   grand_sum  out  sum of all rows transferred so far
//   done       out  all rows transferred; sticky until reset

module rowsum_reader_d #(
    parameter int M     = 3,
    parameter int R     = 5,
    parameter int BASE  = 1,
    parameter int SUM_W = 40
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wrD_done,
    output logic [7:0]       addrbD,
    input  logic [31:0]      doutbD,
    output logic [SUM_W-1:0] row_sum,
    output logic [7:0]       row_idx,
    output logic             row_valid,
    input  logic             row_ready,
    output logic [SUM_W-1:0] grand_sum,
    output logic             done
);

    // The whole matrix must fit in the 8-bit address space without wrapping.
    if (M < 1 || R < 1 || BASE < 0 || BASE + M * R - 1 > 255) begin : g_bad_params
        $error("rowsum_reader_d: matrix does not fit the 8-bit D address space");
    end

    localparam logic [7:0] BASE_ADDR = 8'(BASE);
    localparam logic [7:0] LAST_CNT  = 8'(R - 1);
    localparam logic [7:0] LAST_ROW  = 8'(M - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_OUT,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [7:0]       addr_q;
    logic [7:0]       cnt_q;
    logic [7:0]       row_idx_q;
    logic [SUM_W-1:0] acc_q;
    logic [SUM_W-1:0] acc_d;
    logic [SUM_W-1:0] row_sum_q;
    logic [SUM_W-1:0] grand_q;
    logic             iss_q;
    logic             valid_q;
    logic             done_q;
    logic [SUM_W-1:0] dout_ext;
    logic [7:0]       next_row_addr;

    assign dout_ext = SUM_W'(doutbD);

    // Start address of the row after the one currently held on the output.
    assign next_row_addr = 8'(BASE + (int'(row_idx_q) + 1) * R);

    // iss_q marks that the address presented in the previous cycle was a real
    // read, so the word now on doutbD belongs to the current row.
    always_comb begin
        acc_d = acc_q;
        if (iss_q) begin
            acc_d = acc_q + dout_ext;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            addr_q    <= 8'd0;
            cnt_q     <= 8'd0;
            row_idx_q <= 8'd0;
            acc_q     <= '0;
            row_sum_q <= '0;
            grand_q   <= '0;
            iss_q     <= 1'b0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            acc_q <= acc_d;
            iss_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (wrD_done) begin
                        state_q <= S_READ;
                        addr_q  <= BASE_ADDR;
                        cnt_q   <= 8'd0;
                        acc_q   <= '0;
                    end
                end
                S_READ: begin
                    addr_q <= addr_q + 8'd1;
                    cnt_q  <= cnt_q + 8'd1;
                    iss_q  <= 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // The last word of the row arrives this cycle; capture the
                    // sum including it. addr_q already points at the next row.
                    row_sum_q <= acc_d;
                    valid_q   <= 1'b1;
                    state_q   <= S_OUT;
                end
                S_OUT: begin
                    // valid_q is always high here, so row_ready alone marks a transfer.
                    if (row_ready) begin
                        valid_q <= 1'b0;
                        grand_q <= grand_q + row_sum_q;
                        if (row_idx_q == LAST_ROW) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            row_idx_q <= row_idx_q + 8'd1;
                            acc_q     <= '0;
                            cnt_q     <= 8'd0;
                            addr_q    <= next_row_addr;
                            state_q   <= S_READ;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_DONE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign addrbD    = addr_q;
    assign row_sum   = row_sum_q;
    assign row_idx   = row_idx_q;
    assign row_valid = valid_q;
    assign grand_sum = grand_q;
    assign done      = done_q;

    // A stalled row must not change until the consumer takes it.
    a_hold_stalled_row: assert property (@(posedge clk) disable iff (reset)
        (row_valid && !row_ready) |=>
        (row_valid && $stable(row_sum) && $stable(row_idx) && $stable(addrbD)));

    a_done_sticky: assert property (@(posedge clk) disable iff (reset)
        done |=> done);

endmodule

// File: tb/tb_rowsum_reader_d.sv
// tb/tb_rowsum_reader_d.sv - scoreboard bench for rowsum_reader_d

module tb_rowsum_reader_d;

    logic clk = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // dut 0: default parameters
    logic        rst0, wr0, rdy0, v0, done0;
    logic [7:0]  addr0, idx0;
    logic [31:0] dout0;
    logic [39:0] sum0, g0;
    // dut 1: modulo wrap, one row, 32-bit sums
    logic        rst1, wr1, rdy1, v1, done1;
    logic [7:0]  addr1, idx1;
    logic [31:0] dout1;
    logic [31:0] sum1, g1;
    // dut 2: M=2, R=1, BASE=0
    logic        rst2, wr2, rdy2, v2, done2;
    logic [7:0]  addr2, idx2;
    logic [31:0] dout2;
    logic [39:0] sum2, g2;

    logic [31:0] mem0 [256];
    logic [31:0] mem1 [256];
    logic [31:0] mem2 [256];

    always @(posedge clk) begin
        dout0 <= mem0[addr0];
        dout1 <= mem1[addr1];
        dout2 <= mem2[addr2];
    end

    rowsum_reader_d u_dut0 (
        .clk(clk), .reset(rst0), .wrD_done(wr0), .addrbD(addr0), .doutbD(dout0),
        .row_sum(sum0), .row_idx(idx0), .row_valid(v0), .row_ready(rdy0),
        .grand_sum(g0), .done(done0)
    );

    rowsum_reader_d #(.M(1), .R(5), .BASE(1), .SUM_W(32)) u_dut1 (
        .clk(clk), .reset(rst1), .wrD_done(wr1), .addrbD(addr1), .doutbD(dout1),
        .row_sum(sum1), .row_idx(idx1), .row_valid(v1), .row_ready(rdy1),
        .grand_sum(g1), .done(done1)
    );

    rowsum_reader_d #(.M(2), .R(1), .BASE(0), .SUM_W(40)) u_dut2 (
        .clk(clk), .reset(rst2), .wrD_done(wr2), .addrbD(addr2), .doutbD(dout2),
        .row_sum(sum2), .row_idx(idx2), .row_valid(v2), .row_ready(rdy2),
        .grand_sum(g2), .done(done2)
    );

    logic        mv [3];
    logic        mr [3];
    logic        mrst [3];
    logic        md [3];
    logic [63:0] ms [3];
    logic [7:0]  mi [3];

    assign mv[0] = v0;    assign mv[1] = v1;    assign mv[2] = v2;
    assign mr[0] = rdy0;  assign mr[1] = rdy1;  assign mr[2] = rdy2;
    assign mrst[0] = rst0; assign mrst[1] = rst1; assign mrst[2] = rst2;
    assign md[0] = done0; assign md[1] = done1; assign md[2] = done2;
    assign ms[0] = 64'(sum0); assign ms[1] = 64'(sum1); assign ms[2] = 64'(sum2);
    assign mi[0] = idx0;  assign mi[1] = idx1;  assign mi[2] = idx2;

    // abs_rise >= 0: row_valid must rise on that absolute edge number;
    // otherwise it must rise gap edges after the previous transfer edge.
    typedef struct {
        int          dut;
        logic [63:0] sum;
        int          idx;
        int          abs_rise;
        int          gap;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    function automatic void push(input int d, input logic [63:0] s, input int i,
                                 input int ar, input int g);
        exp_t e;
        e.dut = d; e.sum = s; e.idx = i; e.abs_rise = ar; e.gap = g;
        sb.push_back(e);
    endfunction

    function automatic void drop(input int d);
        for (int j = sb.size() - 1; j >= 0; j--) begin
            if (sb[j].dut == d) sb.delete(j);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic monitor();
        bit   seen [3];
        int   rise [3];
        int   last_x [3];
        int   k;
        exp_t e;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                if (mrst[d]) begin
                    seen[d] = 1'b0;
                end else if (mv[d]) begin
                    if (!seen[d]) begin
                        seen[d] = 1'b1;
                        rise[d] = cyc;
                    end
                    if (mr[d]) begin
                        k = -1;
                        for (int j = 0; j < sb.size(); j++) begin
                            if (k < 0 && sb[j].dut == d) k = j;
                        end
                        check($sformatf("row_expected_d%0d", d), 64'(k >= 0), 64'd1);
                        if (k >= 0) begin
                            e = sb[k];
                            sb.delete(k);
                            check($sformatf("row_sum_d%0d_r%0d", d, e.idx), ms[d], e.sum);
                            check($sformatf("row_idx_d%0d_r%0d", d, e.idx), 64'(mi[d]), 64'(e.idx));
                            if (e.abs_rise >= 0)
                                check($sformatf("rise_edge_d%0d_r%0d", d, e.idx), 64'(rise[d]), 64'(e.abs_rise));
                            else
                                check($sformatf("rise_gap_d%0d_r%0d", d, e.idx), 64'(rise[d] - last_x[d]), 64'(e.gap));
                        end
                        last_x[d] = cyc + 1;
                        seen[d] = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic wait_done(input int d, input int budget);
        int n = 0;
        while (!md[d] && n < budget) begin
            tick();
            n++;
        end
        check($sformatf("done_reached_d%0d", d), 64'(md[d]), 64'd1);
    endtask

    task automatic check_zero0(input string tag);
        check({tag, "_ctl"}, 64'({addr0, idx0, v0, done0}), 64'd0);
        check({tag, "_row_sum"}, 64'(sum0), 64'd0);
        check({tag, "_grand"}, 64'(g0), 64'd0);
    endtask

    task automatic push_default_rows(input int e0);
        push(0, 64'd175, 0, e0 + 6, 0);
        push(0, 64'd425, 1, -1, 6);
        push(0, 64'd675, 2, -1, 6);
    endtask

    logic [7:0] alog[$];

    initial begin
        int e0;
        int n;
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
        wr0 = 1'b0;  wr1 = 1'b0;  wr2 = 1'b0;
        rdy0 = 1'b1; rdy1 = 1'b1; rdy2 = 1'b1;
        for (int a = 0; a < 256; a++) begin
            mem0[a] = 32'h0000_1000 + 32'(a);
            mem1[a] = 32'd0;
            mem2[a] = 32'd0;
        end
        for (int k = 0; k < 15; k++) mem0[1 + k] = 32'(15 + 10 * k);
        for (int k = 1; k <= 5; k++) mem1[k] = 32'hFFFF_FFFF;
        mem2[0] = 32'd7;
        mem2[1] = 32'd9;

        fork
            monitor();
        join_none

        repeat (3) tick();
        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
        tick();
        check_zero0("reset_state");

        // wrD_done low: nothing moves
        repeat (100) begin
            tick();
            check("idle_hold", 64'({addr0, v0, done0}), 64'd0);
        end

        // main run, ready tied high, wrD_done dropped shortly after start
        wr0 = 1'b1;
        e0 = cyc + 1;
        push_default_rows(e0);
        alog.delete();
        alog.push_back(addr0);
        n = 0;
        while (!done0 && n < 100) begin
            tick();
            n++;
            if (n == 3) wr0 = 1'b0;
            if (addr0 != alog[$]) alog.push_back(addr0);
        end
        check("run1_done", 64'(done0), 64'd1);
        check("run1_grand", 64'(g0), 64'd1275);
        check("addr_seq_len", 64'(alog.size()), 64'd17);
        for (int i = 0; i < alog.size() && i < 17; i++)
            check($sformatf("addr_seq_%0d", i), 64'(alog[i]), 64'(i));

        // DONE ignores wrD_done and holds outputs
        for (int i = 0; i < 12; i++) begin
            wr0 = (i >= 2 && i < 6);
            tick();
            check("done_hold", 64'({addr0, v0, done0, idx0}), 64'({8'd16, 1'b0, 1'b1, 8'd2}));
        end
        check("done_hold_sum", 64'(sum0), 64'd675);
        check("done_hold_grand", 64'(g0), 64'd1275);

        // backpressure on row 1
        wr0 = 1'b0;
        rst0 = 1'b1;
        tick();
        check_zero0("reset_after_done");
        rst0 = 1'b0;
        wr0 = 1'b1;
        e0 = cyc + 1;
        push_default_rows(e0);
        tick();
        wr0 = 1'b0;
        n = 0;
        while (idx0 != 8'd1 && n < 50) begin tick(); n++; end
        check("bp_row0_xfer", 64'(idx0), 64'd1);
        rdy0 = 1'b0;
        n = 0;
        while (!v0 && n < 50) begin tick(); n++; end
        check("bp_row1_valid", 64'(v0), 64'd1);
        repeat (10) begin
            tick();
            check("bp_hold", 64'({sum0, idx0, addr0, v0}), 64'({40'd425, 8'd1, 8'd11, 1'b1}));
        end
        rdy0 = 1'b1;
        wait_done(0, 60);
        check("bp_grand", 64'(g0), 64'd1275);

        // reset during READ of row 1, wrD_done held high, then clean rerun
        rst0 = 1'b1;
        tick();
        rst0 = 1'b0;
        wr0 = 1'b1;
        e0 = cyc + 1;
        push_default_rows(e0);
        n = 0;
        while (idx0 != 8'd1 && n < 50) begin tick(); n++; end
        check("mid_row0_xfer", 64'(idx0), 64'd1);
        tick();
        tick();
        rst0 = 1'b1;
        drop(0);
        tick();
        check_zero0("mid_reset");
        rst0 = 1'b0;
        e0 = cyc + 1;
        push_default_rows(e0);
        wait_done(0, 60);
        check("rerun_grand", 64'(g0), 64'd1275);

        // modulo wrap on a 32-bit sum
        wr1 = 1'b1;
        e0 = cyc + 1;
        push(1, 64'hFFFF_FFFB, 0, e0 + 6, 0);
        tick();
        wr1 = 1'b0;
        wait_done(1, 40);
        check("wrap_grand", 64'(g1), 64'hFFFF_FFFB);

        // M=2, R=1, BASE=0
        wr2 = 1'b1;
        e0 = cyc + 1;
        push(2, 64'd7, 0, e0 + 2, 0);
        push(2, 64'd9, 1, -1, 2);
        tick();
        wr2 = 1'b0;
        wait_done(2, 40);
        check("sweep_grand", 64'(g2), 64'd16);

        tick();
        check("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
